// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back data cache controller (32 x 256-bit lines)
// Optional hit/miss counters: define DCACHE_STATS_EN
`timescale 1ns/1ps

module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count_o,
  output logic [31:0]  miss_count_o
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    ALLOCATE   = 3'd3,
    ALLOC_DONE = 3'd4
  } state_t;

  state_t state;

  // Per-line storage; only valid/dirty need a reset value
  logic [21:0]  tag_a  [32];
  logic [255:0] data_a [32];
  logic [31:0]  valid_a;
  logic [31:0]  dirty_a;

  logic [21:0]  req_tag;
  logic [4:0]   req_index;
  logic [2:0]   req_word;
  logic [7:0]   word_base;
  logic         req;
  logic         hit;
  logic [255:0] sel_line;
  logic         unused_addr_bits;

  assign req_tag          = p1_addr_i[31:10];
  assign req_index        = p1_addr_i[9:5];
  assign req_word         = p1_addr_i[4:2];
  assign word_base        = {req_word, 5'b0};
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign hit      = valid_a[req_index] && (tag_a[req_index] == req_tag);
  assign sel_line = data_a[req_index];

  // Load data is the addressed word of the indexed line; invalid lines read as zero
  always_comb begin
    p1_data_o = 32'd0;
    if (valid_a[req_index]) p1_data_o = sel_line[word_base +: 32];
  end

  // Stall and memory request decode; memory strobes come straight from the state register
  always_comb begin
    p1_stall_o   = 1'b1;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = sel_line;
    case (state)
      IDLE:      p1_stall_o = req && !hit;
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_a[req_index], req_index, 5'b0};
      end
      ALLOCATE:  begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {p1_addr_i[31:5], 5'b0};
      end
      default:   p1_stall_o = 1'b1;
    endcase
  end

  // Controller FSM plus valid/dirty bookkeeping; reset abandons any memory transfer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      valid_a <= 32'd0;
      dirty_a <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (p1_MemWrite_i) dirty_a[req_index] <= 1'b1;
            end else begin
              state <= MISS;
            end
          end
        end
        MISS: begin
          if (valid_a[req_index] && dirty_a[req_index]) state <= WRITEBACK;
          else                                          state <= ALLOCATE;
        end
        WRITEBACK: begin
          if (mem_ack_i) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            valid_a[req_index] <= 1'b1;
            dirty_a[req_index] <= 1'b0;
            state              <= ALLOC_DONE;
          end
        end
        ALLOC_DONE: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Line fill on refill ack, word merge on a store hit in IDLE
  always_ff @(posedge clk_i) begin
    if (state == ALLOCATE && mem_ack_i) begin
      data_a[req_index] <= mem_data_i;
      tag_a[req_index]  <= req_tag;
    end else if (state == IDLE && p1_MemWrite_i && hit) begin
      data_a[req_index][word_base +: 32] <= p1_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  // Hit/miss counters: a refilled access counts one miss and then one hit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_count_o  <= 32'd0;
      miss_count_o <= 32'd0;
    end else if (state == IDLE && req) begin
      if (hit) hit_count_o  <= hit_count_o + 32'd1;
      else     miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for dcache_controller
`timescale 1ns/1ps

module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr, wdata, rdata;
  logic         rd, wr, stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic         mem_en, mem_wr, mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst_n),
    .p1_addr_i(addr), .p1_data_i(wdata),
    .p1_MemRead_i(rd), .p1_MemWrite_i(wr),
    .p1_data_o(rdata), .p1_stall_o(stall),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count_o(hit_cnt), .miss_count_o(miss_cnt)
`endif
  );

  typedef struct { logic [31:0] data; logic chk; int stall; } cpu_exp_t;
  typedef struct { logic wr; logic [31:0] addr; int widx; logic [31:0] wval; logic chk; } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  logic [255:0] mem [logic [31:0]];

  int  n_cmp = 0;
  int  n_fail = 0;
  int  lat = 10;
  int  cnt = 0;
  int  wr_hi = 0;
  int  scnt = 0;
  bit  active = 1'b0;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hD000_0000 | a | 32'(k);
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic w, input logic [31:0] a, input int widx,
                          input logic [31:0] wval, input logic chk);
    mem_exp_t e;
    e.wr = w; e.addr = a; e.widx = widx; e.wval = wval; e.chk = chk;
    mem_q.push_back(e);
  endtask

  task automatic cpu_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic chk, input logic [31:0] exp_d, input int exp_stall);
    cpu_exp_t ce;
    bit done;
    ce.data = exp_d; ce.chk = chk; ce.stall = exp_stall;
    cpu_q.push_back(ce);
    @(posedge clk); #1;
    addr = a; wdata = d; rd = r; wr = w; active = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!stall) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL cpu_timeout: addr %h still stalled after 300 cycles", a);
      cpu_q.delete();
      scnt = 0;
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; active = 1'b0;
  endtask

  // Memory model: ack in the lat-th cycle of an enabled request
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (mem_wr) wr_hi++;
      if (mem_en) begin
        cnt++;
        if (cnt >= lat) begin
          mem_ack = 1'b1;
          cnt = 0;
          if (mem_wr) mem[mem_addr] = mem_wdata;
          else        mem_rdata = line_of(mem_addr);
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        cnt = 0;
        mem_ack = 1'b0;
      end
    end
  end

  // Monitor: memory transactions and CPU responses against the scoreboard
  always @(negedge clk) begin : mon
    mem_exp_t me;
    cpu_exp_t ce;
    if (mem_en && mem_ack) begin
      if (mem_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL mem_unexpected: addr %h write %b", mem_addr, mem_wr);
      end else begin
        me = mem_q.pop_front();
        check("mem_write", 32'(mem_wr), 32'(me.wr));
        check("mem_addr", mem_addr, me.addr);
        if (me.chk) check("mem_wb_word", mem_wdata[me.widx*32 +: 32], me.wval);
      end
    end
    if (active) begin
      if (stall) scnt++;
      else if (cpu_q.size() != 0) begin
        ce = cpu_q.pop_front();
        check("stall_cycles", 32'(scnt), 32'(ce.stall));
        if (ce.chk) check("load_data", rdata, ce.data);
        scnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] l;
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'h100 + 32'(k);
    l[31:0] = 32'd1024;
    mem[32'h0] = l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'h4000 + 32'(k);
    mem[32'h400] = l;

    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_mem_en", 32'(mem_en), 32'd0);
    check("reset_mem_wr", 32'(mem_wr), 32'd0);
    check("reset_data", rdata, 32'd0);
    rst_n = 1'b1;
    wr_hi = 0;

    // Cold read miss, latency 10
    push_mem(1'b0, 32'h0, 0, 32'd0, 1'b0);
    cpu_op(1'b1, 1'b0, 32'h0, 32'd0, 1'b1, 32'd1024, 13);
    check("no_write_on_clean_miss", 32'(wr_hi), 32'd0);

    // Store hit then load back
    cpu_op(1'b0, 1'b1, 32'h4, 32'h5, 1'b0, 32'd0, 0);
    cpu_op(1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 32'h5, 0);

    // Conflict miss on dirty line: writeback then allocate
    push_mem(1'b1, 32'h0, 1, 32'h5, 1'b1);
    push_mem(1'b0, 32'h400, 0, 32'd0, 1'b0);
    cpu_op(1'b1, 1'b0, 32'h400, 32'd0, 1'b1, 32'h4000, 23);

`ifdef DCACHE_STATS_EN
    check("miss_count", miss_cnt, 32'd2);
    check("hit_count", hit_cnt, 32'd4);
`endif

    // Reset in the middle of ALLOCATE
    @(posedge clk); #1;
    addr = 32'h800; rd = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (mem_en) begin seen = 1'b1; break; end
      end
      check("alloc_started", 32'(seen), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; rd = 1'b0;
    #1;
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_mem(1'b0, 32'h400, 0, 32'd0, 1'b0);
    cpu_op(1'b1, 1'b0, 32'h400, 32'd0, 1'b1, 32'h4000, 13);

    // Read+write together: store wins, old word visible
    cpu_op(1'b1, 1'b1, 32'h404, 32'hA, 1'b1, 32'h4001, 0);
    cpu_op(1'b1, 1'b0, 32'h404, 32'd0, 1'b1, 32'hA, 0);

    // Minimum latency: dirty writeback then refill of line 0
    lat = 1;
    push_mem(1'b1, 32'h400, 1, 32'hA, 1'b1);
    push_mem(1'b0, 32'h0, 0, 32'd0, 1'b0);
    cpu_op(1'b1, 1'b0, 32'h0, 32'd0, 1'b1, 32'd1024, 5);
    cpu_op(1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 32'h5, 0);

    // Store miss allocates, then merges the word
    push_mem(1'b0, 32'h40, 0, 32'd0, 1'b0);
    cpu_op(1'b0, 1'b1, 32'h44, 32'h77, 1'b0, 32'd0, 4);
    cpu_op(1'b1, 1'b0, 32'h40, 32'd0, 1'b1, 32'hD000_0040, 0);
    cpu_op(1'b1, 1'b0, 32'h44, 32'd0, 1'b1, 32'h77, 0);

    // Idle with no request
    repeat (4) @(posedge clk);
    #1;
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_mem_en", 32'(mem_en), 32'd0);

    repeat (3) @(posedge clk);
    check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameters: none; geometry fixed: direct-mapped, 32 lines x 256 bits, tag=addr[31:10], index=addr[9:5], word=addr[4:2].
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 p1_addr_i  in  32  CPU byte address (word aligned).
REQ-005 p1_data_i  in  32  CPU store data.
REQ-006 p1_MemRead_i  in  1  CPU load request.
REQ-007 p1_MemWrite_i  in  1  CPU store request.
REQ-008 p1_data_o  out  32  load data.
REQ-009 p1_stall_o  out  1  CPU must hold request while high.
REQ-010 mem_addr_o  out  32  line address to Data_Memory, low 5 bits zero.
REQ-011 mem_data_o  out  256  writeback line.
REQ-012 mem_enable_o  out  1  memory request valid.
REQ-013 mem_write_o  out  1  1=line write, 0=line read.
REQ-014 mem_data_i  in  256  refill line.
REQ-015 mem_ack_i  in  1  one-cycle pulse completing current memory request.

Function
REQ-016 States: IDLE, MISS, WRITEBACK, ALLOCATE, ALLOC_DONE.
REQ-017 hit = valid[index] and tag[index]==addr[31:10]; request = MemRead or MemWrite.
REQ-018 IDLE read hit: p1_data_o = selected word combinationally, p1_stall_o=0, zero added latency.
REQ-019 IDLE write hit: word written at the rising edge, dirty[index] set, p1_stall_o=0.
REQ-020 IDLE request with miss: p1_stall_o=1 combinationally same cycle; next state MISS.
REQ-021 MISS: if valid and dirty -> WRITEBACK, else -> ALLOCATE; p1_stall_o=1.
REQ-022 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag,index,5'b0}, mem_data_o=line; held until mem_ack_i; then ALLOCATE.
REQ-023 ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={p1_addr_i[31:5],5'b0}; on mem_ack_i load mem_data_i, tag updated, valid=1, dirty=0; then ALLOC_DONE.
REQ-024 ALLOC_DONE: mem_enable_o=0, p1_stall_o=1 for one cycle; then IDLE, where the held request hits per REQ-018/019.
REQ-025 Outside WRITEBACK/ALLOCATE mem_enable_o=0, mem_write_o=0; mem_ack_i ignored.
REQ-026 MemRead and MemWrite both high: treated as write; p1_data_o still shows old word.
REQ-027 No request in IDLE: p1_stall_o=0, no state change, arrays unchanged.
REQ-028 Stall path spans any memory latency >=1 cycle; ack in the cycle the request is first raised is accepted.

Reset
REQ-029 rst_i low: state=IDLE, all valid/dirty bits cleared, mem_enable_o=0, mem_write_o=0, p1_stall_o=0 (no request), p1_data_o=0 for invalid lines; data/tag arrays need not clear.
REQ-030 Reset mid-WRITEBACK/ALLOCATE abandons the transfer immediately; pending acks after release ignored in IDLE.

Configuration
REQ-031 Macro DCACHE_STATS_EN defined: add outputs hit_count_o[31:0], miss_count_o[31:0]; miss increments on IDLE->MISS, hit increments on each IDLE cycle with request and hit (a refilled access counts one miss and one hit); both reset to 0, wrap at 2^32.
REQ-032 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-033 Reset, read 0x00000000 with memory line word0=1024, ack latency 10 -> stall 13 cycles, then p1_data_o=1024, mem_write_o never high.
REQ-034 Write 0x5 to 0x00000004 after REQ-033 -> no stall, subsequent read 0x00000004 returns 0x5 with stall 0.
REQ-035 Read 0x00000400 (same index, new tag) after REQ-034 -> WRITEBACK with mem_addr_o=0x00000000, line word1=0x5, then ALLOCATE at 0x00000400.
REQ-036 Assert rst_i low during ALLOCATE -> mem_enable_o=0 at once; after release, read 0x00000400 misses again.
REQ-037 MemRead=MemWrite=1 to hit address, data 0xA -> word becomes 0xA, dirty set, stall 0.
REQ-038 With DCACHE_STATS_EN: sequence REQ-033..035 -> miss_count_o=2, hit_count_o=4.
